vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Ports: pixClk, reset (async, active-high), en; outputs x, y (raw
// coordinates), valid/hSync/vSync (delayed PIPE_DLY stages),
// sol/sof/eof strobes aligned to x/y, frameCnt.
// Optional macro VGA_FRAME_CNT_EN builds the frame counter; without it
// frameCnt is constant 0.
module vga_timing_gen #(
    parameter int H_AV     = 640,
    parameter int H_FP     = 16,
    parameter int H_SP     = 96,
    parameter int H_BP     = 48,
    parameter int V_AV     = 480,
    parameter int V_FP     = 10,
    parameter int V_SP     = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIPE_DLY = 2,
    parameter int CW       = 10,
    parameter int FCW      = 8
) (
    input  logic           pixClk,
    input  logic           reset,
    input  logic           en,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           valid,
    output logic           hSync,
    output logic           vSync,
    output logic           sol,
    output logic           sof,
    output logic           eof,
    output logic [FCW-1:0] frameCnt
);

    localparam int H_TOTAL = H_AV + H_FP + H_SP + H_BP;
    localparam int V_TOTAL = V_AV + V_FP + V_SP + V_BP;
    localparam int T_MAX   = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_AV);
    localparam logic [CW-1:0] V_ACT  = CW'(V_AV);
    localparam logic [CW-1:0] H_SS   = CW'(H_AV + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_AV + H_FP + H_SP);
    localparam logic [CW-1:0] V_SS   = CW'(V_AV + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_AV + V_FP + V_SP);
    localparam logic [CW-1:0] H_EOF  = CW'(H_AV - 1);
    localparam logic [CW-1:0] V_EOF  = CW'(V_AV - 1);

    // Stage word layout: {valid, hSync level, vSync level}
    localparam logic [2:0] ST_RST = {1'b0, ~H_POL, ~V_POL};

    if ((64'd1 << CW) <= 64'(T_MAX)) begin : g_err_cw
        $error("vga_timing_gen: CW too small for the mode totals");
    end
    if (PIPE_DLY > 8 || PIPE_DLY < 0) begin : g_err_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..8");
    end
    if (H_FP == 0 || H_SP == 0 || H_BP == 0 ||
        V_FP == 0 || V_SP == 0 || V_BP == 0) begin : g_err_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          h_act;
    logic          v_act;
    logic          vid;
    logic          at_origin;
    logic [2:0]    st [PIPE_DLY+1];

    always_comb begin
        x_nxt = x + 1'b1;
        y_nxt = y;
        if (x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y == V_LAST) ? '0 : y + 1'b1;
        end
        h_act     = (x_nxt >= H_SS) && (x_nxt < H_SE);
        v_act     = (y_nxt >= V_SS) && (y_nxt < V_SE);
        vid       = (x_nxt < H_ACT) && (y_nxt < V_ACT);
        at_origin = (x_nxt == '0) && (y_nxt == '0);
    end

    // st[0] is aligned with x/y; st[PIPE_DLY] drives the outputs.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            x   <= H_LAST;
            y   <= V_LAST;
            sol <= 1'b0;
            sof <= 1'b0;
            eof <= 1'b0;
            for (int i = 0; i <= PIPE_DLY; i++) st[i] <= ST_RST;
        end else begin
            sol <= en && (x_nxt == '0);
            sof <= en && at_origin;
            eof <= en && (x_nxt == H_EOF) && (y_nxt == V_EOF);
            if (en) begin
                x     <= x_nxt;
                y     <= y_nxt;
                st[0] <= {vid, h_act ~^ H_POL, v_act ~^ V_POL};
                for (int i = 1; i <= PIPE_DLY; i++) st[i] <= st[i-1];
            end
        end
    end

    assign {valid, hSync, vSync} = st[PIPE_DLY];

`ifdef VGA_FRAME_CNT_EN
    // Starts at all ones so the first frame after reset reads 0.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset)
            frameCnt <= '1;
        else if (en && at_origin)
            frameCnt <= frameCnt + 1'b1;
    end
`else
    assign frameCnt = '0;
`endif

endmodule
